// File: rtl/debug_display_pager_if.sv
// rtl/debug_display_pager_if.sv - channel inputs and display outputs of the debug pager
interface debug_display_pager_if #(
    parameter int NUM_CH   = 4,
    parameter int CH_WIDTH = 24
) ();
    localparam int NDIG  = CH_WIDTH / 4;
    localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH*CH_WIDTH-1:0] ch_data;
    logic [SEL_W-1:0]           sel;
    logic                       auto_en;
    logic                       next_btn;
    logic                       freeze;
    logic [4*NDIG-1:0]          hex_digits;
    logic [NDIG-1:0]            digit_blank;
    logic [SEL_W-1:0]           cur_ch;
    logic [NUM_CH-1:0]          changed;
    logic                       frozen;

    modport master (
        output ch_data, sel, auto_en, next_btn, freeze,
        input  hex_digits, digit_blank, cur_ch, changed, frozen
    );

    modport slave (
        input  ch_data, sel, auto_en, next_btn, freeze,
        output hex_digits, digit_blank, cur_ch, changed, frozen
    );
endinterface

// File: rtl/debug_display_pager.sv
// rtl/debug_display_pager.sv - pages NUM_CH debug channels onto one hex digit bank
module debug_display_pager #(
    parameter int NUM_CH      = 4,
    parameter int CH_WIDTH    = 24,
    parameter int AUTO_PERIOD = 50000000,
    parameter int LZ_BLANK    = 1
) (
    input logic                   clock,
    input logic                   reset,
    debug_display_pager_if.slave  bus
);
    localparam int NDIG  = CH_WIDTH / 4;
    localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int TMR_W = $clog2(AUTO_PERIOD);

    localparam logic [SEL_W-1:0] LAST_CH   = SEL_W'(NUM_CH - 1);
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(AUTO_PERIOD - 1);
    localparam logic [NDIG-1:0]  BLANK_RST = (LZ_BLANK != 0) ? ~NDIG'(1) : '0;

    logic [SEL_W-1:0]           ptr_q, ptr_d;
    logic [TMR_W-1:0]           timer_q, timer_d;
    logic                       btn_q;
    logic                       frozen_q;
    logic [4*NDIG-1:0]          hex_q, hex_d;
    logic [NDIG-1:0]            blank_q, blank_d;
    logic [NUM_CH-1:0]          chg_q, chg_d;
    logic [NUM_CH*CH_WIDTH-1:0] prev_q;

    logic [SEL_W-1:0]    sel_clamped;
    logic [SEL_W-1:0]    ptr_next;
    logic                btn_edge;
    logic                expire;
    logic [CH_WIDTH-1:0] page;
    logic                zero_run;

    always_comb begin
        sel_clamped = bus.sel;
        if (32'(bus.sel) >= 32'(NUM_CH)) begin
            sel_clamped = LAST_CH;
        end

        ptr_next = (ptr_q == LAST_CH) ? '0 : ptr_q + SEL_W'(1);
        btn_edge = bus.next_btn & ~btn_q;
        expire   = (timer_q == TMR_LAST);

        ptr_d   = ptr_q;
        timer_d = timer_q;
        if (!bus.freeze) begin
            if (!bus.auto_en) begin
                ptr_d   = sel_clamped;
                timer_d = '0;
            end else if (btn_edge || expire) begin
                // A button press landing on the expiry cycle still advances only once.
                ptr_d   = ptr_next;
                timer_d = '0;
            end else begin
                timer_d = timer_q + TMR_W'(1);
            end
        end

        // Page data follows the pointer being written, so the page and cur_ch switch together.
        page     = bus.ch_data[int'(ptr_d)*CH_WIDTH +: CH_WIDTH];
        zero_run = 1'b1;
        blank_d  = '0;
        for (int k = NDIG - 1; k >= 0; k--) begin
            zero_run   = zero_run & (page[4*k +: 4] == 4'h0);
            blank_d[k] = (LZ_BLANK != 0) && (k != 0) && zero_run;
        end
        hex_d = page[4*NDIG-1:0];
        if (bus.freeze) begin
            hex_d   = hex_q;
            blank_d = blank_q;
        end

        // The clear term wins over the set term: the channel is on screen this cycle.
        for (int i = 0; i < NUM_CH; i++) begin
            chg_d[i] = (chg_q[i] |
                        (bus.ch_data[i*CH_WIDTH +: CH_WIDTH] != prev_q[i*CH_WIDTH +: CH_WIDTH]))
                       & ~(!bus.freeze && (ptr_d == SEL_W'(i)));
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr_q    <= '0;
            timer_q  <= '0;
            btn_q    <= 1'b0;
            frozen_q <= 1'b0;
            hex_q    <= '0;
            blank_q  <= BLANK_RST;
            chg_q    <= '0;
            prev_q   <= '0;
        end else begin
            ptr_q    <= ptr_d;
            timer_q  <= timer_d;
            btn_q    <= bus.next_btn;
            frozen_q <= bus.freeze;
            hex_q    <= hex_d;
            blank_q  <= blank_d;
            chg_q    <= chg_d;
            prev_q   <= bus.ch_data;
        end
    end

    assign bus.cur_ch      = ptr_q;
    assign bus.hex_digits  = hex_q;
    assign bus.digit_blank = blank_q;
    assign bus.changed     = chg_q;
    assign bus.frozen      = frozen_q;
endmodule

// File: tb/tb_debug_display_pager.sv
// tb/tb_debug_display_pager.sv - directed self-checking bench for debug_display_pager
module tb_debug_display_pager;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clock = ~clock;

    debug_display_pager_if #(.NUM_CH(4), .CH_WIDTH(24)) bus ();

    debug_display_pager #(
        .NUM_CH(4), .CH_WIDTH(24), .AUTO_PERIOD(8), .LZ_BLANK(1)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_ch(input int i, input logic [23:0] v);
        bus.ch_data[i*24 +: 24] = v;
    endtask

    task automatic test_reset();
        bus.ch_data = '0; bus.sel = '0; bus.auto_en = 1'b0; bus.next_btn = 1'b0; bus.freeze = 1'b1;
        reset = 1'b0;
        tick(); tick();
        total++; if (bus.cur_ch !== 2'd0) begin bad++; $display("FAIL rst_cur_ch got=%0d want=0", bus.cur_ch); end
        total++; if (bus.hex_digits !== 24'h0) begin bad++; $display("FAIL rst_hex got=%h want=000000", bus.hex_digits); end
        total++; if (bus.digit_blank !== 6'b111110) begin bad++; $display("FAIL rst_blank got=%b want=111110", bus.digit_blank); end
        total++; if (bus.changed !== 4'b0000) begin bad++; $display("FAIL rst_changed got=%b want=0000", bus.changed); end
        total++; if (bus.frozen !== 1'b0) begin bad++; $display("FAIL rst_frozen got=%b want=0", bus.frozen); end
        bus.freeze = 1'b0;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_manual();
        logic [2:0] wide_sel;
        set_ch(2, 24'h00A3F0);
        set_ch(3, 24'h000FFF);
        bus.sel = 2'd2;
        tick();
        total++; if (bus.cur_ch !== 2'd2) begin bad++; $display("FAIL man_cur_ch got=%0d want=2", bus.cur_ch); end
        total++; if (bus.hex_digits !== 24'h00A3F0) begin bad++; $display("FAIL man_hex got=%h want=00a3f0", bus.hex_digits); end
        total++; if (bus.digit_blank !== 6'b110000) begin bad++; $display("FAIL man_blank got=%b want=110000", bus.digit_blank); end
        total++; if (bus.changed !== 4'b1000) begin bad++; $display("FAIL man_changed got=%b want=1000", bus.changed); end
        wide_sel = 3'd7;
        bus.sel = wide_sel[1:0];
        tick();
        total++; if (bus.cur_ch !== 2'd3) begin bad++; $display("FAIL man_sel7 got=%0d want=3", bus.cur_ch); end
        total++; if (bus.hex_digits !== 24'h000FFF) begin bad++; $display("FAIL man_hex3 got=%h want=000fff", bus.hex_digits); end
        total++; if (bus.digit_blank !== 6'b111000) begin bad++; $display("FAIL man_blank3 got=%b want=111000", bus.digit_blank); end
        total++; if (bus.changed !== 4'b0000) begin bad++; $display("FAIL man_clr3 got=%b want=0000", bus.changed); end
        bus.sel = 2'd3;
        bus.next_btn = 1'b1;
        tick();
        total++; if (bus.cur_ch !== 2'd3) begin bad++; $display("FAIL man_btn_ignored got=%0d want=3", bus.cur_ch); end
        bus.next_btn = 1'b0;
        tick();
        total++; if (bus.cur_ch !== 2'd3) begin bad++; $display("FAIL man_sel3 got=%0d want=3", bus.cur_ch); end
    endtask

    task automatic test_auto();
        logic [1:0] exp;
        bus.auto_en = 1'b1;
        for (int k = 1; k <= 36; k++) begin
            tick();
            if (k < 8) exp = 2'd3;
            else if (k < 16) exp = 2'd0;
            else if (k < 24) exp = 2'd1;
            else if (k < 28) exp = 2'd2;
            else if (k < 36) exp = 2'd3;
            else exp = 2'd0;
            total++; if (bus.cur_ch !== exp) begin bad++; $display("FAIL auto_step k=%0d got=%0d want=%0d", k, bus.cur_ch, exp); end
            bus.next_btn = (k == 27);
        end
    endtask

    task automatic test_coincide();
        for (int k = 37; k <= 43; k++) begin
            tick();
            total++; if (bus.cur_ch !== 2'd0) begin bad++; $display("FAIL coin_pre k=%0d got=%0d want=0", k, bus.cur_ch); end
        end
        bus.next_btn = 1'b1;
        tick();
        total++; if (bus.cur_ch !== 2'd1) begin bad++; $display("FAIL coin_once got=%0d want=1", bus.cur_ch); end
        bus.next_btn = 1'b0;
        for (int k = 45; k <= 51; k++) begin
            tick();
            total++; if (bus.cur_ch !== 2'd1) begin bad++; $display("FAIL coin_hold k=%0d got=%0d want=1", k, bus.cur_ch); end
        end
        tick();
        total++; if (bus.cur_ch !== 2'd2) begin bad++; $display("FAIL coin_next got=%0d want=2", bus.cur_ch); end
    endtask

    task automatic test_freeze();
        bus.auto_en = 1'b0;
        bus.sel = 2'd1;
        set_ch(1, 24'h123456);
        tick();
        total++; if (bus.hex_digits !== 24'h123456) begin bad++; $display("FAIL frz_pre_hex got=%h want=123456", bus.hex_digits); end
        total++; if (bus.digit_blank !== 6'b000000) begin bad++; $display("FAIL frz_pre_blank got=%b want=000000", bus.digit_blank); end
        bus.freeze = 1'b1;
        tick();
        total++; if (bus.frozen !== 1'b1) begin bad++; $display("FAIL frz_frozen got=%b want=1", bus.frozen); end
        set_ch(1, 24'h000001);
        bus.sel = 2'd0;
        bus.next_btn = 1'b1;
        tick();
        total++; if (bus.hex_digits !== 24'h123456) begin bad++; $display("FAIL frz_hold_hex got=%h want=123456", bus.hex_digits); end
        total++; if (bus.cur_ch !== 2'd1) begin bad++; $display("FAIL frz_hold_ch got=%0d want=1", bus.cur_ch); end
        total++; if (bus.changed[1] !== 1'b1) begin bad++; $display("FAIL frz_chg_set got=%b want=1", bus.changed[1]); end
        bus.next_btn = 1'b0;
        bus.sel = 2'd1;
        bus.freeze = 1'b0;
        tick();
        total++; if (bus.hex_digits !== 24'h000001) begin bad++; $display("FAIL frz_rel_hex got=%h want=000001", bus.hex_digits); end
        total++; if (bus.digit_blank !== 6'b111110) begin bad++; $display("FAIL frz_rel_blank got=%b want=111110", bus.digit_blank); end
        total++; if (bus.changed[1] !== 1'b0) begin bad++; $display("FAIL frz_rel_chg got=%b want=0", bus.changed[1]); end
        total++; if (bus.frozen !== 1'b0) begin bad++; $display("FAIL frz_rel_frozen got=%b want=0", bus.frozen); end
    endtask

    task automatic test_changed();
        bus.sel = 2'd0;
        tick();
        total++; if (bus.changed !== 4'b0000) begin bad++; $display("FAIL chg_idle got=%b want=0000", bus.changed); end
        set_ch(2, 24'h00A3F1);
        tick();
        total++; if (bus.changed !== 4'b0100) begin bad++; $display("FAIL chg_set got=%b want=0100", bus.changed); end
        tick();
        total++; if (bus.changed !== 4'b0100) begin bad++; $display("FAIL chg_sticky got=%b want=0100", bus.changed); end
        bus.sel = 2'd2;
        tick();
        total++; if (bus.changed !== 4'b0000) begin bad++; $display("FAIL chg_clear got=%b want=0000", bus.changed); end
        total++; if (bus.cur_ch !== 2'd2) begin bad++; $display("FAIL chg_cur_ch got=%0d want=2", bus.cur_ch); end
        set_ch(2, 24'h00A3F2);
        tick();
        total++; if (bus.changed !== 4'b0000) begin bad++; $display("FAIL chg_clear_wins got=%b want=0000", bus.changed); end
        total++; if (bus.hex_digits !== 24'h00A3F2) begin bad++; $display("FAIL chg_hex got=%h want=00a3f2", bus.hex_digits); end
    endtask

    task automatic test_reset_mid();
        bus.auto_en = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            total++; if (bus.cur_ch !== 2'd2) begin bad++; $display("FAIL rmid_pre k=%0d got=%0d want=2", k, bus.cur_ch); end
        end
        #2;
        reset = 1'b0;
        #1;
        total++; if (bus.cur_ch !== 2'd0) begin bad++; $display("FAIL rmid_cur_ch got=%0d want=0", bus.cur_ch); end
        total++; if (bus.hex_digits !== 24'h0) begin bad++; $display("FAIL rmid_hex got=%h want=000000", bus.hex_digits); end
        total++; if (bus.digit_blank !== 6'b111110) begin bad++; $display("FAIL rmid_blank got=%b want=111110", bus.digit_blank); end
        total++; if (bus.changed !== 4'b0000) begin bad++; $display("FAIL rmid_changed got=%b want=0000", bus.changed); end
        total++; if (bus.frozen !== 1'b0) begin bad++; $display("FAIL rmid_frozen got=%b want=0", bus.frozen); end
        tick();
        total++; if (bus.cur_ch !== 2'd0) begin bad++; $display("FAIL rmid_held got=%0d want=0", bus.cur_ch); end
        reset = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 1) begin
                total++; if (bus.changed !== 4'b1110) begin bad++; $display("FAIL rmid_first_chg got=%b want=1110", bus.changed); end
                total++; if (bus.hex_digits !== 24'h0) begin bad++; $display("FAIL rmid_first_hex got=%h want=000000", bus.hex_digits); end
            end
            total++; if (bus.cur_ch !== ((k < 8) ? 2'd0 : 2'd1)) begin bad++; $display("FAIL rmid_auto k=%0d got=%0d want=%0d", k, bus.cur_ch, (k < 8) ? 0 : 1); end
        end
        total++; if (bus.hex_digits !== 24'h000001) begin bad++; $display("FAIL rmid_page1 got=%h want=000001", bus.hex_digits); end
    endtask

    initial begin
        test_reset();
        test_manual();
        test_auto();
        test_coincide();
        test_freeze();
        test_changed();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
